// File: rtl/btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
//
// Conditions an asynchronous, bouncy push-button / event line for use in the
// clk domain. The raw input is passed through a two-flop synchronizer, and
// the synchronized sample must hold a new value for STABLE_CYCLES consecutive
// clocks before the debounced level follows it. Each qualified low->high
// change produces a single-cycle rise pulse (intended to drive a counter
// enable so that one press advances the count by exactly one).
//
// Parameters:
//   STABLE_CYCLES  consecutive synchronized samples needed to accept a level
//                  change, legal range 1..65535 (default 4)
//
// Ports:
//   clk     in   rising-edge clock
//   rst     in   asynchronous, active-high reset
//   btn_in  in   raw asynchronous input, may glitch at any time
//   level   out  debounced level, registered
//   rise    out  one-cycle pulse on a qualified low->high transition
//   fall    out  one-cycle pulse on a qualified high->low transition
//                (present only when BTN_DEBOUNCE_FALL_EN is defined)
//
// Build option:
//   BTN_DEBOUNCE_FALL_EN  when defined, adds the fall port and its register.
//                         When undefined, a qualified release only updates
//                         level.
// ---------------------------------------------------------------------------
module btn_debounce #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic level,
  output logic rise
`ifdef BTN_DEBOUNCE_FALL_EN
  ,
  output logic fall
`endif
);

  // Wide enough to hold STABLE_CYCLES itself; the count never exceeds
  // STABLE_CYCLES-1 because it is cleared whenever a checking state exits.
  localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);

  // Qualification completes on the sample where cnt+1 == STABLE_CYCLES,
  // which is the same as cnt == STABLE_CYCLES-1.
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = '0;

  typedef enum logic [1:0] {
    LOW      = 2'd0,
    CHK_HIGH = 2'd1,
    HIGH     = 2'd2,
    CHK_LOW  = 2'd3
  } state_t;

  logic          s1;
  logic          s2;
  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          level_nxt;
  logic          rise_nxt;
`ifdef BTN_DEBOUNCE_FALL_EN
  logic          fall_nxt;
`endif

  // Two-flop synchronizer. Only s2 is ever looked at by the FSM, so s1 is
  // the only flop that can go metastable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn_in;
      s2 <= s1;
    end
  end

  // State and qualification counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LOW;
      cnt   <= CNT_ZERO;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic. The checking states count how many consecutive
  // samples have agreed with the candidate level; any opposing sample
  // drops straight back to the stable state with the count cleared, so
  // qualification always restarts from zero.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rise_nxt  = 1'b0;
`ifdef BTN_DEBOUNCE_FALL_EN
    fall_nxt  = 1'b0;
`endif

    unique case (state)
      LOW: begin
        cnt_nxt = CNT_ZERO;
        if (s2) begin
          if (STABLE_CYCLES == 1) begin
            state_nxt = HIGH;
            rise_nxt  = 1'b1;
          end else begin
            state_nxt = CHK_HIGH;
            cnt_nxt   = CNT_ONE;
          end
        end
      end

      CHK_HIGH: begin
        if (!s2) begin
          state_nxt = LOW;
          cnt_nxt   = CNT_ZERO;
        end else if (cnt == CNT_LAST) begin
          state_nxt = HIGH;
          cnt_nxt   = CNT_ZERO;
          rise_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end

      HIGH: begin
        cnt_nxt = CNT_ZERO;
        if (!s2) begin
          if (STABLE_CYCLES == 1) begin
            state_nxt = LOW;
`ifdef BTN_DEBOUNCE_FALL_EN
            fall_nxt  = 1'b1;
`endif
          end else begin
            state_nxt = CHK_LOW;
            cnt_nxt   = CNT_ONE;
          end
        end
      end

      CHK_LOW: begin
        if (s2) begin
          state_nxt = HIGH;
          cnt_nxt   = CNT_ZERO;
        end else if (cnt == CNT_LAST) begin
          state_nxt = LOW;
          cnt_nxt   = CNT_ZERO;
`ifdef BTN_DEBOUNCE_FALL_EN
          fall_nxt  = 1'b1;
`endif
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end

      default: begin
        state_nxt = LOW;
        cnt_nxt   = CNT_ZERO;
      end
    endcase

    // While checking a release the accepted level is still high, and while
    // checking a press it is still low.
    level_nxt = (state_nxt == HIGH) || (state_nxt == CHK_LOW);
  end

  // Outputs are registered alongside the state so they change on the same
  // edge as the qualified transition and are glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      level <= level_nxt;
      rise  <= rise_nxt;
    end
  end

`ifdef BTN_DEBOUNCE_FALL_EN
  // Release pulse register, only built when the fall output is wanted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fall <= 1'b0;
    end else begin
      fall <= fall_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_btn_debounce.sv
// ---------------------------------------------------------------------------
// tb_btn_debounce
//
// Scoreboard bench for btn_debounce. The stimulus side drives btn_in/rst one
// clock at a time and runs a behavioural model: the input is delayed by two
// captures, and the debounced level flips once STABLE_CYCLES consecutive
// delayed samples disagree with it. Expected levels and expected pulses are
// queued; a monitor on the falling edge pops and compares them against the
// DUT outputs.
// ---------------------------------------------------------------------------
module tb_btn_debounce;

  localparam int S = 4;

  logic clk = 1'b0;
  logic rst;
  logic btn_in;
  logic level;
  logic rise;
`ifdef BTN_DEBOUNCE_FALL_EN
  logic fall;
`endif

  btn_debounce #(.STABLE_CYCLES(S)) dut (
    .clk    (clk),
    .rst    (rst),
    .btn_in (btn_in),
    .level  (level),
    .rise   (rise)
`ifdef BTN_DEBOUNCE_FALL_EN
    ,
    .fall   (fall)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int edge_num;
    bit is_rise;
  } pulse_t;

  pulse_t pulse_q[$];
  bit     level_q[$];

  int checks    = 0;
  int failures  = 0;
  int edge_num  = 0;
  int rise_seen = 0;

  // Reference model state: two-deep capture history, accepted level, and
  // the length of the current run of samples disagreeing with that level.
  bit m_d1;
  bit m_d2;
  bit m_level;
  int m_run;

  task automatic checkOutput(input string name, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s edge=%0d got=%0d expected=%0d", name, edge_num, got, exp);
    end
  endtask

  task automatic modelClear();
    m_d1    = 1'b0;
    m_d2    = 1'b0;
    m_level = 1'b0;
    m_run   = 0;
  endtask

  // One clock of stimulus. The model is advanced with the values present
  // at the edge, then the new inputs are driven just after the edge. A reset
  // driven here clears the DUT immediately, so the model is cleared too and
  // any pulse predicted for this edge is dropped.
  task automatic applyStimulus(input bit b, input bit r);
    bit sample;
    bit pend;
    bit pend_rise;
    pend      = 1'b0;
    pend_rise = 1'b0;
    @(posedge clk);
    edge_num++;
    if (rst) begin
      modelClear();
    end else begin
      sample = m_d2;
      m_d2   = m_d1;
      m_d1   = btn_in;
      if (sample != m_level) begin
        m_run++;
        if (m_run == S) begin
          m_level   = sample;
          m_run     = 0;
          pend      = 1'b1;
          pend_rise = sample;
        end
      end else begin
        m_run = 0;
      end
    end
    #1;
    btn_in = b;
    rst    = r;
    if (r) begin
      modelClear();
      pend = 1'b0;
    end
    if (pend) begin
`ifdef BTN_DEBOUNCE_FALL_EN
      pulse_q.push_back('{edge_num: edge_num, is_rise: pend_rise});
`else
      if (pend_rise) pulse_q.push_back('{edge_num: edge_num, is_rise: 1'b1});
`endif
    end
    level_q.push_back(m_level);
  endtask

  task automatic hold(input bit b, input int n);
    for (int i = 0; i < n; i++) applyStimulus(b, 1'b0);
  endtask

  // Asserts reset between edges (after the monitor has sampled) and checks
  // that the outputs clear without waiting for a clock.
  task automatic asyncReset();
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("async_level", level, 0);
    checkOutput("async_rise", rise, 0);
`ifdef BTN_DEBOUNCE_FALL_EN
    checkOutput("async_fall", fall, 0);
`endif
    modelClear();
  endtask

  // Monitor: one expected level per clock, plus a pulse whenever the
  // scoreboard head is due on this edge.
  always @(negedge clk) begin
    bit     exp_level;
    bit     exp_rise;
    bit     exp_fall;
    pulse_t p;
    if (level_q.size() > 0) begin
      exp_level = level_q.pop_front();
      exp_rise  = 1'b0;
      exp_fall  = 1'b0;
      if (pulse_q.size() > 0 && pulse_q[0].edge_num <= edge_num) begin
        p = pulse_q.pop_front();
        if (p.edge_num == edge_num) begin
          exp_rise = p.is_rise;
          exp_fall = !p.is_rise;
        end else begin
          checkOutput("stale_pulse", p.edge_num, edge_num);
        end
      end
      checkOutput("level", level, 32'(exp_level));
      checkOutput("rise", rise, 32'(exp_rise));
`ifdef BTN_DEBOUNCE_FALL_EN
      checkOutput("fall", fall, 32'(exp_fall));
`endif
      if (rise === 1'b1) rise_seen++;
    end
  end

  initial begin
    int base;
    int len;
    bit val;
    modelClear();
    rst    = 1'b1;
    btn_in = 1'b1;

    // Reset held with the input high, then released: full requalification.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1);
    hold(1'b1, 10);

    // Clean release and press.
    hold(1'b0, 10);
    hold(1'b1, 10);
    hold(1'b0, 10);

    // Bounce: short high run, one low, then steady high, then release.
    hold(1'b1, 3);
    hold(1'b0, 1);
    hold(1'b1, 12);
    hold(1'b0, 12);

    // Asynchronous reset from HIGH with the input still high.
    hold(1'b1, 10);
    asyncReset();
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1);
    hold(1'b1, 10);

    // Reset in the middle of a press qualification, then idle low.
    hold(1'b0, 10);
    hold(1'b1, 5);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1);
    hold(1'b0, 10);

    // Counter-style use: three presses give exactly three rise pulses.
    base = rise_seen;
    for (int k = 0; k < 3; k++) begin
      hold(1'b1, 8);
      hold(1'b0, 10);
    end
    checkOutput("press_count", rise_seen - base, 3);
    hold(1'b0, 20);
    checkOutput("press_count_idle", rise_seen - base, 3);

    // Random bounce runs around the qualification threshold, with the
    // occasional reset.
    for (int seg = 0; seg < 250; seg++) begin
      val = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 2 * S + 2);
      if ($urandom_range(0, 39) == 0) begin
        for (int i = 0; i < $urandom_range(1, 2); i++) applyStimulus(val, 1'b1);
      end
      hold(val, len);
    end

    hold(1'b0, 20);
    @(negedge clk);
    #1;
    checkOutput("pulse_queue_empty", pulse_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
